// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and derives stall and
// forward-select decisions for the two decode source operands.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int FWD_EN     = 1,
    localparam int FW        = $clog2(STAGES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic              id_wr_en_i,
    input  logic [REG_AW-1:0] id_wr_reg_i,
    input  logic              id_is_load_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o,
    output logic [FW-1:0]     in_flight_o,
    output logic [15:0]       stall_cnt_o
);
    logic [STAGES-1:0]             v_q, v_d, wr_q, wr_d, ld_q, ld_d;
    logic [STAGES-1:0][REG_AW-1:0] reg_q, reg_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          hz_a, hz_b, issue;
    logic [FW-1:0]                 in_flight;

    // Scans oldest to youngest so the youngest matching writer wins.
    function automatic logic [FW:0] lookup(input logic used, input logic [REG_AW-1:0] r);
        logic          hz;
        logic [FW-1:0] sel;
        hz  = 1'b0;
        sel = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (used && r != '0 && v_q[i] && wr_q[i] && reg_q[i] == r) begin
                if (FWD_EN != 0) begin
                    hz  = ld_q[i] && i < LOAD_STAGE;
                    sel = hz ? '0 : FW'(i + 1);
                end else begin
                    hz  = i < STAGES - 1;
                    sel = hz ? '0 : FW'(STAGES);
                end
            end
        end
        return {hz, sel};
    endfunction

    assign {hz_a, fwd_a_o} = lookup(id_rs_used_i, id_rs_i);
    assign {hz_b, fwd_b_o} = lookup(id_rt_used_i, id_rt_i);
    assign stall_o         = (hz_a | hz_b) & id_valid_i & ~flush_i;
    assign issue           = id_valid_i & ~stall_o & ~flush_i;
    assign in_flight_o     = in_flight;
    assign stall_cnt_o     = cnt_q;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < STAGES; i++) in_flight = in_flight + FW'(v_q[i] & wr_q[i]);
    end

    // Entries always advance; flush kills the stage-0 entry as it moves to stage 1.
    always_comb begin
        v_d    = {v_q[STAGES-2:0], issue};
        v_d[1] = v_q[0] & ~flush_i;
        wr_d   = {wr_q[STAGES-2:0], id_wr_en_i && id_wr_reg_i != '0};
        ld_d   = {ld_q[STAGES-2:0], id_is_load_i};
        reg_d  = {reg_q[STAGES-2:0], id_wr_reg_i};
        cnt_d  = (stall_o && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            reg_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            wr_q  <= wr_d;
            ld_q  <= ld_d;
            reg_q <= reg_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven check of a forwarding and a stall-only scoreboard.
module tb_hazard_scoreboard;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       id_valid = 1'b0, rs_used = 1'b0, rt_used = 1'b0, wr_en = 1'b0, is_load = 1'b0, flush = 1'b0;
    logic [4:0] rs = '0, rt = '0, wr_reg = '0;
    logic       st0, st1;
    logic [1:0] fa0, fb0, inf0, fa1, fb1, inf1;
    logic [15:0] cnt0, cnt1;
    int n_vec = 0, n_err = 0;

    typedef struct {
        logic v, ru, tu, we, ld, fl, nf, cf, es;
        logic [4:0] rs, rt, wr;
        int fa, fb, inf, cnt;
    } vec_t;

    vec_t tbl[23];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard u_fwd (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .id_wr_en_i(wr_en), .id_wr_reg_i(wr_reg),
        .id_is_load_i(is_load), .flush_i(flush), .stall_o(st0), .fwd_a_o(fa0), .fwd_b_o(fb0),
        .in_flight_o(inf0), .stall_cnt_o(cnt0));

    hazard_scoreboard #(.FWD_EN(0)) u_nf (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .id_wr_en_i(wr_en), .id_wr_reg_i(wr_reg),
        .id_is_load_i(is_load), .flush_i(flush), .stall_o(st1), .fwd_a_o(fa1), .fwd_b_o(fb1),
        .in_flight_o(inf1), .stall_cnt_o(cnt1));

    function automatic vec_t mk(int v, int a, int b, int ru, int tu, int we, int wr, int ld, int fl,
                                int nf, int cf, int es, int fa, int fb, int inf, int cnt);
        vec_t e;
        e.v = v[0]; e.rs = 5'(a); e.rt = 5'(b); e.ru = ru[0]; e.tu = tu[0]; e.we = we[0];
        e.wr = 5'(wr); e.ld = ld[0]; e.fl = fl[0]; e.nf = nf[0]; e.cf = cf[0]; e.es = es[0];
        e.fa = fa; e.fb = fb; e.inf = inf; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(string name, int idx, int act, int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, want);
        end
    endtask

    task automatic drive(vec_t e);
        id_valid = e.v; rs = e.rs; rt = e.rt; rs_used = e.ru; rt_used = e.tu;
        wr_en = e.we; wr_reg = e.wr; is_load = e.ld; flush = e.fl;
    endtask

    task automatic check(vec_t e, int idx);
        chk("stall", idx, e.nf ? int'(st1) : int'(st0), int'(e.es));
        if (e.cf) begin
            chk("fwd_a", idx, e.nf ? int'(fa1) : int'(fa0), e.fa);
            chk("fwd_b", idx, e.nf ? int'(fb1) : int'(fb0), e.fb);
        end
        chk("in_flight", idx, e.nf ? int'(inf1) : int'(inf0), e.inf);
        chk("stall_cnt", idx, e.nf ? int'(cnt1) : int'(cnt0), e.cnt);
    endtask

    task automatic step(vec_t e, int idx);
        drive(e);
        exp_q.push_back(e);
        @(negedge clk);
        check(exp_q.pop_front(), idx);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(int idx);
        chk("rst_stall", idx, int'(st0), 0); chk("rst_fa", idx, int'(fa0), 0);
        chk("rst_fb", idx, int'(fb0), 0); chk("rst_inf", idx, int'(inf0), 0);
        chk("rst_cnt", idx, int'(cnt0), 0); chk("rst_nf_stall", idx, int'(st1), 0);
        chk("rst_nf_inf", idx, int'(inf1), 0); chk("rst_nf_cnt", idx, int'(cnt1), 0);
    endtask

    initial begin
        //            v rs rt ru tu we wr ld fl nf cf es fa fb inf cnt
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        tbl[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0);
        tbl[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0);
        tbl[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 1);
        tbl[8]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[11] = mk(1, 0, 0, 1, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[12] = mk(1, 4, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[14] = mk(1, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1);
        tbl[15] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[17] = mk(1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1);
        tbl[18] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[19] = mk(0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 0, 0, 0, 2, 1);
        tbl[22] = mk(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1, 0, 0, 0, 2, 1);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(100);
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) step(tbl[i], i);

        // Asynchronous reset with three writers in flight, away from any edge.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("inf_full", 101, int'(inf0), 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(102);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(1, 11, 12, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 103);

        // Stall-only instance: dependent read waits until the writer reaches the last stage.
        step(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 1, 0, 0, 0, 0, 0), 200);
        step(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0), 201);
        step(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1), 202);
        step(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 1, 2), 203);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
